// File: rtl/btb_update_unit.sv
// BTB write side: buffers taken resolved-branch records in a FIFO and drains them into the BTB write port when fetch is idle.
// Latency 2 cycles from record transfer to btb_we; upd_ready drops when full or flushing. Optional merge with newest entry: BTB_UPDATE_COALESCE_EN.
module btb_update_unit #(
  parameter int DEPTH     = 4,
  parameter int INDEX_W   = 10,
  parameter int TAG_W     = 4,
  parameter int CONTENT_W = 13
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         upd_valid,
  output logic                         upd_ready,
  input  logic [31:0]                  upd_pc,
  input  logic [31:0]                  upd_target,
  input  logic                         upd_taken,
  input  logic                         flush,
  input  logic                         btb_read_busy,
  output logic                         btb_we,
  output logic [INDEX_W-1:0]           btb_waddr,
  output logic [TAG_W+CONTENT_W-1:0]   btb_wdata,
  output logic [$clog2(DEPTH):0]       fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [INDEX_W-1:0]   idx;
    logic [TAG_W-1:0]     tag;
    logic [CONTENT_W-1:0] content;
  } entry_t;

  entry_t                       mem_q [DEPTH];
  logic   [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic                         btb_we_q;
  logic   [INDEX_W-1:0]         btb_waddr_q;
  logic   [TAG_W+CONTENT_W-1:0] btb_wdata_q;

  entry_t         new_entry;
  entry_t         head;
  logic [AW-1:0]  newest_a;
  logic [PW-1:0]  count;
  logic           full, empty, pop, xfer, push, coal_wr;

  assign new_entry = '{idx:     upd_pc[INDEX_W+1:2],
                       tag:     upd_pc[INDEX_W+TAG_W+1:INDEX_W+2],
                       content: upd_target[CONTENT_W+1:2]};

  // Address/target bits outside the index, tag and content fields carry no BTB information.
  logic unused_bits;
  assign unused_bits = ^{upd_pc[31:INDEX_W+TAG_W+2], upd_pc[1:0],
                         upd_target[31:CONTENT_W+2], upd_target[1:0]};

  assign count    = wptr_q - rptr_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head     = mem_q[rptr_q[AW-1:0]];
  assign newest_a = wptr_q[AW-1:0] - AW'(1);
  assign pop      = !empty && !btb_read_busy && !flush;

`ifdef BTB_UPDATE_COALESCE_EN
  logic coalesce_hit;
  // The newest entry is only leaving this cycle when it is also the head being popped.
  assign coalesce_hit = !empty && (mem_q[newest_a].idx == new_entry.idx)
                        && !(pop && (count == PW'(1)));
  assign upd_ready    = (!full || coalesce_hit) && !flush;
  assign xfer         = upd_valid && upd_ready;
  assign push         = xfer && upd_taken && !coalesce_hit;
  assign coal_wr      = xfer && upd_taken && coalesce_hit;
`else
  assign upd_ready    = !full && !flush;
  assign xfer         = upd_valid && upd_ready;
  assign push         = xfer && upd_taken;
  assign coal_wr      = 1'b0;
`endif

  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= new_entry;
    end else if (coal_wr) begin
      mem_q[newest_a] <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      btb_we_q    <= 1'b0;
      btb_waddr_q <= '0;
      btb_wdata_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      btb_we_q <= pop;
      if (pop) begin
        btb_waddr_q <= head.idx;
        btb_wdata_q <= {head.tag, head.content};
      end
    end
  end

  assign btb_we     = btb_we_q;
  assign btb_waddr  = btb_waddr_q;
  assign btb_wdata  = btb_wdata_q;
  assign fifo_count = count;

endmodule

// File: tb/tb_btb_update_unit.sv
// Directed bench for btb_update_unit: reset, write path, filter, backpressure, flush, async reset, coalesce.
module tb_btb_update_unit;

  logic        clk;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        flush;
  logic        btb_read_busy;
  logic        btb_we;
  logic [9:0]  btb_waddr;
  logic [16:0] btb_wdata;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  btb_update_unit #(.DEPTH(4), .INDEX_W(10), .TAG_W(4), .CONTENT_W(13)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .flush         (flush),
    .btb_read_busy (btb_read_busy),
    .btb_we        (btb_we),
    .btb_waddr     (btb_waddr),
    .btb_wdata     (btb_wdata),
    .fifo_count    (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd_valid  = v;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = tk;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    btb_read_busy = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    check("reset_we",    32'(btb_we),     32'd0);
    check("reset_waddr", 32'(btb_waddr),  32'd0);
    check("reset_wdata", 32'(btb_wdata),  32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_ready", 32'(upd_ready),  32'd1);
    #10 rst_n = 1'b1;
    step();

    // Basic write: index 0x08D, {tag 1, content 0x159E}
    drive(1'b1, 32'h0000_1234, 32'h0000_5678, 1'b1);
    #1 check("basic_ready", 32'(upd_ready), 32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("basic_count1", 32'(fifo_count), 32'd1);
    check("basic_we_c1",  32'(btb_we),     32'd0);
    step();
    check("basic_we_c2", 32'(btb_we),     32'd1);
    check("basic_waddr", 32'(btb_waddr),  32'h08D);
    check("basic_wdata", 32'(btb_wdata),  32'h0359E);
    check("basic_count0",32'(fifo_count), 32'd0);
    step();
    check("basic_we_off",   32'(btb_we),    32'd0);
    check("basic_waddr_hold",32'(btb_waddr),32'h08D);

    // Not-taken records are consumed but never written
    drive(1'b1, 32'h0000_0100, 32'h0000_0200, 1'b0);
    #1 check("nt_ready", 32'(upd_ready), 32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("nt_count", 32'(fifo_count), 32'd0);
    check("nt_we_c1", 32'(btb_we),     32'd0);
    step();
    check("nt_we_c2", 32'(btb_we),     32'd0);

    // Backpressure: fill with busy high, then drain in order
    btb_read_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 32'h2000 + 32'(4 * i), 1'b1);
      #1 check("bp_ready_fill", 32'(upd_ready), 32'd1);
      step();
    end
    drive(1'b1, 32'h1010, 32'h2010, 1'b1);
    #1;
    check("bp_ready_full", 32'(upd_ready),  32'd0);
    check("bp_count_full", 32'(fifo_count), 32'd4);
    step();
    check("bp_count_hold", 32'(fifo_count), 32'd4);
    check("bp_we_busy",    32'(btb_we),     32'd0);
    btb_read_busy = 1'b0;
    #1 check("bp_ready_full_pop", 32'(upd_ready), 32'd0);
    step();
    check("bp_we0",    32'(btb_we),    32'd1);
    check("bp_waddr0", 32'(btb_waddr), 32'd0);
    check("bp_wdata0", 32'(btb_wdata), 32'h2800);
    check("bp_ready_after_pop", 32'(upd_ready), 32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("bp_count_pushpop", 32'(fifo_count), 32'd3);
    for (int k = 1; k < 5; k++) begin
      check("bp_we_k",    32'(btb_we),    32'd1);
      check("bp_waddr_k", 32'(btb_waddr), 32'(k));
      check("bp_wdata_k", 32'(btb_wdata), 32'h2800 + 32'(k));
      step();
    end
    check("bp_we_done",    32'(btb_we),     32'd0);
    check("bp_count_done", 32'(fifo_count), 32'd0);

    // Flush drops queued entries and the flush-cycle record
    btb_read_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 32'h0100 + 32'(4 * i), 1'b1);
      step();
    end
    check("fl_count3", 32'(fifo_count), 32'd3);
    drive(1'b1, 32'h3100, 32'h0200, 1'b1);
    flush = 1'b1;
    #1 check("fl_ready", 32'(upd_ready), 32'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("fl_count0", 32'(fifo_count), 32'd0);
    check("fl_we",     32'(btb_we),     32'd0);
    btb_read_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_we", 32'(btb_we), 32'd0);
    end

    // Asynchronous reset between write pulses
    btb_read_busy = 1'b1;
    drive(1'b1, 32'h4000, 32'h0400, 1'b1);
    step();
    drive(1'b1, 32'h4004, 32'h0404, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    btb_read_busy = 1'b0;
    step();
    check("ar_we_pulse1", 32'(btb_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_we_async",    32'(btb_we),     32'd0);
    check("ar_count_async", 32'(fifo_count), 32'd0);
    check("ar_waddr_async", 32'(btb_waddr),  32'd0);
    #2 rst_n = 1'b1;
    step();
    check("ar_we_after",    32'(btb_we),     32'd0);
    check("ar_count_after", 32'(fifo_count), 32'd0);

    // Same-index records: merged when coalescing, two slots otherwise
    btb_read_busy = 1'b1;
    drive(1'b1, 32'h0000_0040, 32'h0000_0080, 1'b1);
    step();
    drive(1'b1, 32'h0000_0040, 32'h0000_00C0, 1'b1);
    #1 check("co_ready", 32'(upd_ready), 32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef BTB_UPDATE_COALESCE_EN
    check("co_count", 32'(fifo_count), 32'd1);
`else
    check("co_count", 32'(fifo_count), 32'd2);
`endif
    btb_read_busy = 1'b0;
    step();
    check("co_we1",    32'(btb_we),    32'd1);
    check("co_waddr1", 32'(btb_waddr), 32'h010);
`ifdef BTB_UPDATE_COALESCE_EN
    check("co_wdata1", 32'(btb_wdata), 32'h030);
    step();
    check("co_we2", 32'(btb_we), 32'd0);
`else
    check("co_wdata1", 32'(btb_wdata), 32'h020);
    step();
    check("co_we2",    32'(btb_we),    32'd1);
    check("co_wdata2", 32'(btb_wdata), 32'h030);
`endif
    check("co_count_end", 32'(fifo_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_update_unit.md
Name: btb_update_unit

Overview:
- Write side of the branch target buffer. Accepts resolved-branch records from the execute/commit stage through a valid/ready handshake and buffers them in a small FIFO.
- Converts each record into a BTB index, tag and compressed target.
- Drains the FIFO into the BTB's single write port when the fetch-side lookup is not using the array.
- Sits between the branch resolution logic and the BTB storage, opposite the fetch-stage BTB read path.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2
- INDEX_W, 10, BTB index width (1024 entries); index = pc[INDEX_W+1:2]
- TAG_W, 4, tag width; tag = pc[INDEX_W+TAG_W+1:INDEX_W+2]
- CONTENT_W, 13, compressed target width; content = target[CONTENT_W+1:2]

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- upd_valid  in  1  resolved-branch record valid
- upd_ready  out  1  unit can accept a record this cycle
- upd_pc  in  32  PC of the resolved branch
- upd_target  in  32  resolved target address
- upd_taken  in  1  branch resolved taken
- flush  in  1  discard all pending updates
- btb_read_busy  in  1  fetch is reading the BTB this cycle; write must defer
- btb_we  out  1  BTB write enable (registered)
- btb_waddr  out  INDEX_W  BTB write index (registered)
- btb_wdata  out  TAG_W+CONTENT_W  {tag, content} (registered)
- fifo_count  out  $clog2(DEPTH)+1  number of pending entries

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO empty; read/write pointers 0.
  - btb_we=0, btb_waddr=0, btb_wdata=0, fifo_count=0.
  - Any in-flight records are lost.
- Handshake:
  - upd_ready = !full && !flush, combinational from registered state.
  - A record transfers when upd_valid && upd_ready; upd_valid without upd_ready is ignored, and the producer must hold the record.
- Enqueue filter:
  - Transferred records with upd_taken=1 are enqueued as {index, tag, content} computed from upd_pc/upd_target.
  - upd_target[1:0] and upd_target[31:CONTENT_W+2] are discarded.
  - Transferred records with upd_taken=0 are consumed (ready honoured) but not enqueued.
- Drain:
  - Pop when count>0 && !btb_read_busy && !flush.
  - A pop at edge E drives btb_we=1 with the head entry in the cycle after E.
  - btb_we=0 in every other cycle; btb_waddr/btb_wdata hold their last values while btb_we=0.
- Latency: record transferred in cycle c into an empty FIFO with btb_read_busy=0 → btb_we=1 in cycle c+2.
- Simultaneous push and pop: both take effect; count unchanged. No bypass path: a record never reaches btb_we without first occupying the FIFO.
- Full: upd_ready=0 even if a pop occurs in the same cycle. Throughput when full is 1 write per cycle.
- Pointer wrap: pointers are $clog2(DEPTH)+1 bits; full = MSBs differ and low bits equal.
- flush=1:
  - At the next edge, the FIFO is emptied and btb_we=0 in the following cycle.
  - Flush overrides both push and pop in the same cycle.
  - A write already registered (btb_we high in the flush cycle) completes.
- btb_read_busy stuck high: the FIFO fills, upd_ready drops, and nothing is dropped.

Optional Feature:
- Macro: BTB_UPDATE_COALESCE_EN
- Defined:
  - If a taken record's index equals the index of the newest FIFO entry, and that entry is not being popped this cycle, the record overwrites that entry's tag/content; count is unchanged.
  - upd_ready = (!full || coalesce_hit) && !flush.
  - If the newest entry is also being popped this cycle, the record is enqueued normally.
- Undefined: no index comparison; every taken record takes a new slot.

Test Plan:
- Reset/basic write: release rst_n; one taken record pc=0x0000_1234, target=0x0000_5678, btb_read_busy=0 → btb_we=1 two cycles later, btb_waddr=0x08D, btb_wdata={4'h1, 13'h159E}; fifo_count returns to 0.
- Not-taken filter: pc=0x100, taken=0 → upd_ready=1 and the record is accepted; btb_we stays 0; fifo_count stays 0.
- Backpressure: btb_read_busy=1; push 5 taken records with distinct indices → upd_ready=0 after the 4th; fifo_count=4. Release busy → 4 consecutive btb_we pulses in FIFO order, then the 5th record is accepted.
- Flush: 3 entries queued with busy=1; assert flush 1 cycle with upd_valid=1 → fifo_count=0 next cycle, the flush-cycle record is not accepted, and no btb_we follows.
- Async reset mid-drain: rst_n low between two btb_we pulses → btb_we=0 immediately without a clock edge; fifo_count=0.
- Coalesce (macro defined): busy=1; push pc=0x40 target=0x80, then pc=0x40 target=0xC0 → fifo_count=1. Release busy → one write, btb_wdata content=13'h030.
